// File: rtl/fifo_pkg.sv
`timescale 1ns/100ps
// fifo_pkg: shared pointer helpers for the async FIFO read and write controllers.
//   ptr_t     : (AW+1)-bit pointer type for the default 16-entry FIFO
//   bin2gray  : binary to Gray conversion (operates zero-extended to 32 bits)
//   gray2bin  : Gray to binary conversion by XOR-prefix from the MSB down
package fifo_pkg;

   localparam int FIFO_DEPTH = 16;
   localparam int FIFO_AW    = $clog2(FIFO_DEPTH);

   typedef logic [FIFO_AW:0] ptr_t;

   // Callers zero-extend narrower pointers; the zero upper bits leave the
   // low bits of both conversions unchanged, so one width serves all sizes.
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
`timescale 1ns/100ps
// sync_2ff: two-flop synchronizer for a Gray-coded pointer crossing clock domains.
//   clk_sys : destination-domain clock
//   rst_b   : asynchronous active-low reset, clears both stages
//   d       : source-domain value (must change at most one bit at a time)
//   q       : stage-2 output, safe to use in the clk_sys domain
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] s1_q;
   logic [WIDTH-1:0] s2_q;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
      end
   end

   assign q = s2_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
`timescale 1ns/100ps
// fifo_rd_ctrl: read-side controller of an asynchronous FIFO. Holds no storage;
// it drives the read port of the external dual-port memory.
//   r_clk, r_rst_n   : read clock, asynchronous active-low reset
//   r_en             : pop request (ignored while r_empty)
//   w_ptr_gray       : write pointer in Gray code from the write domain
//   r_ptr_gray       : registered read pointer in Gray code for the write domain
//   r_addr           : memory read address
//   mem_rdata/r_data : combinational memory data, passed through as show-ahead head
//   r_empty, r_almost_empty, r_level : registered occupancy status
//   r_underflow      : one-cycle pulse after a pop attempted while empty
module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AE_LEVEL   = 1,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                  r_clk,
   input  logic                  r_rst_n,
   input  logic                  r_en,
   input  logic [AW:0]           w_ptr_gray,
   output logic [AW:0]           r_ptr_gray,
   output logic [AW-1:0]         r_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic                  r_empty,
   output logic                  r_almost_empty,
   output logic [AW:0]           r_level,
   output logic                  r_underflow
);

   localparam logic [AW:0] AE_LVL = (AW+1)'(AE_LEVEL);

   logic [AW:0] wq2;
   logic [AW:0] wq2_bin;
   logic [AW:0] r_bin_q,      r_bin_d;
   logic [AW:0] r_ptr_gray_q, r_ptr_gray_d;
   logic [AW:0] r_level_q,    r_level_d;
   logic        r_empty_q,    r_empty_d;
   logic        r_ae_q,       r_ae_d;
   logic        r_uf_q,       r_uf_d;
   logic        pop;

   sync_2ff #(.WIDTH(AW+1)) u_wptr_sync (
      .clk_sys (r_clk),
      .rst_b   (r_rst_n),
      .d       (w_ptr_gray),
      .q       (wq2)
   );

   // Flags are computed from the next read pointer so that popping the last
   // entry raises r_empty on the same edge that advances r_bin. The synced
   // write pointer only ever lags the true one, so flags err toward empty.
   always_comb begin
      pop          = r_en && !r_empty_q;
      r_bin_d      = r_bin_q + (AW+1)'(pop);
      r_ptr_gray_d = (AW+1)'(bin2gray(32'(r_bin_d)));
      wq2_bin      = (AW+1)'(gray2bin(32'(wq2)));
      r_level_d    = wq2_bin - r_bin_d;
      r_empty_d    = (r_ptr_gray_d == wq2);
      r_ae_d       = (r_level_d <= AE_LVL);
      r_uf_d       = r_en && r_empty_q;
   end

   always_ff @(posedge r_clk or negedge r_rst_n) begin
      if (!r_rst_n) begin
         r_bin_q      <= '0;
         r_ptr_gray_q <= '0;
         r_level_q    <= '0;
         r_empty_q    <= 1'b1;
         r_ae_q       <= 1'b1;
         r_uf_q       <= 1'b0;
      end else begin
         r_bin_q      <= r_bin_d;
         r_ptr_gray_q <= r_ptr_gray_d;
         r_level_q    <= r_level_d;
         r_empty_q    <= r_empty_d;
         r_ae_q       <= r_ae_d;
         r_uf_q       <= r_uf_d;
      end
   end

   assign r_addr         = r_bin_q[AW-1:0];
   assign r_ptr_gray     = r_ptr_gray_q;
   assign r_level        = r_level_q;
   assign r_empty        = r_empty_q;
   assign r_almost_empty = r_ae_q;
   assign r_underflow    = r_uf_q;
   assign r_data         = mem_rdata;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
`timescale 1ns/100ps
module tb_fifo_rd_ctrl;
   import fifo_pkg::*;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic            r_clk = 1'b0;
   logic            w_clk = 1'b0;
   logic            r_rst_n;
   logic            r_en;
   logic [AW:0]     w_ptr_gray;
   logic [AW:0]     r_ptr_gray;
   logic [AW-1:0]   r_addr;
   logic [DW-1:0]   mem_rdata;
   logic [DW-1:0]   r_data;
   logic            r_empty;
   logic            r_almost_empty;
   logic [AW:0]     r_level;
   logic            r_underflow;

   logic [DW-1:0]   mem [DEPTH];
   logic            wr_on = 1'b0;
   logic            wr_go = 1'b0;
   logic [AW:0]     w_ptr_dir;
   logic [AW:0]     w_ptr_rnd = '0;
   int              n_checks = 0;
   int              n_errors = 0;
   int              w_cnt = 0;
   int              pop_cnt = 0;
   logic [DW-1:0]   sb [$];

   assign w_ptr_gray = wr_on ? w_ptr_rnd : w_ptr_dir;
   assign mem_rdata  = mem[r_addr];

   always #5 r_clk = ~r_clk;
   initial begin
      #0.3;
      forever #3.5 w_clk = ~w_clk;
   end

   fifo_rd_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AE_LEVEL(1)) dut (
      .r_clk          (r_clk),
      .r_rst_n        (r_rst_n),
      .r_en           (r_en),
      .w_ptr_gray     (w_ptr_gray),
      .r_ptr_gray     (r_ptr_gray),
      .r_addr         (r_addr),
      .mem_rdata      (mem_rdata),
      .r_data         (r_data),
      .r_empty        (r_empty),
      .r_almost_empty (r_almost_empty),
      .r_level        (r_level),
      .r_underflow    (r_underflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge r_clk);
      #1;
   endtask

   // Write side: memory preload for the directed phases, then random pushes.
   initial begin
      logic [AW:0]   wb;
      logic [DW-1:0] d;
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i * 7 + 3);
      forever begin
         @(posedge w_clk);
         if (wr_go && (w_cnt - pop_cnt) < DEPTH && $urandom_range(0, 1) == 1) begin
            wb = (AW+1)'(w_cnt);
            d  = 8'($urandom);
            mem[wb[AW-1:0]] = d;
            sb.push_back(d);
            w_cnt++;
            wb = (AW+1)'(w_cnt);
            w_ptr_rnd = (AW+1)'(bin2gray(32'(wb)));
         end
      end
   end

   initial begin
      bit pop;
      int occ;
      int guard;
      r_rst_n   = 1'b1;
      r_en      = 1'b0;
      w_ptr_dir = '0;

      // asynchronous reset between clock edges
      #2 r_rst_n = 1'b0;
      #1;
      chk("rst_empty", 32'(r_empty), 1);
      chk("rst_ptr",   32'(r_ptr_gray), 0);
      chk("rst_level", 32'(r_level), 0);
      chk("rst_addr",  32'(r_addr), 0);
      chk("rst_ae",    32'(r_almost_empty), 1);
      chk("rst_uf",    32'(r_underflow), 0);
      repeat (2) tick();
      r_rst_n = 1'b1;
      repeat (3) tick();

      // latency: one write becomes visible after the second edge
      w_ptr_dir = 5'h01;
      tick();
      chk("lat_k_empty", 32'(r_empty), 1);
      tick();
      chk("lat_k1_empty", 32'(r_empty), 1);
      tick();
      chk("lat_k2_empty", 32'(r_empty), 0);
      chk("lat_k2_level", 32'(r_level), 1);
      chk("lat_k2_ae",    32'(r_almost_empty), 1);
      chk("lat_k2_data",  32'(r_data), 8'h03);
      r_en = 1'b1;
      tick();
      r_en = 1'b0;
      chk("pop1_empty", 32'(r_empty), 1);
      chk("pop1_ptr",   32'(r_ptr_gray), 5'h01);
      chk("pop1_addr",  32'(r_addr), 1);
      chk("pop1_level", 32'(r_level), 0);

      // reset mid-operation, then full drain of 16 entries with r_en held
      #2 r_rst_n = 1'b0;
      #1;
      chk("rst2_ptr",   32'(r_ptr_gray), 0);
      chk("rst2_empty", 32'(r_empty), 1);
      chk("rst2_addr",  32'(r_addr), 0);
      w_ptr_dir = 5'h18;
      r_en      = 1'b1;
      tick();
      r_rst_n = 1'b1;
      tick();
      chk("hold1_addr", 32'(r_addr), 0);
      chk("hold1_uf",   32'(r_underflow), 1);
      tick();
      chk("hold2_ptr",   32'(r_ptr_gray), 0);
      chk("hold2_empty", 32'(r_empty), 1);
      tick();
      chk("hold3_empty", 32'(r_empty), 0);
      chk("hold3_ptr",   32'(r_ptr_gray), 0);
      chk("hold3_level", 32'(r_level), 16);
      for (int i = 0; i < 16; i++) begin
         chk("drain_addr",  32'(r_addr), 32'(i));
         chk("drain_level", 32'(r_level), 32'(16 - i));
         chk("drain_empty", 32'(r_empty), 0);
         chk("drain_data",  32'(r_data), 32'(8'(i * 7 + 3)));
         chk("drain_ae",    32'(r_almost_empty), ((16 - i) <= 1) ? 1 : 0);
         tick();
      end
      chk("drained_empty", 32'(r_empty), 1);
      chk("drained_ptr",   32'(r_ptr_gray), 5'h18);
      chk("drained_level", 32'(r_level), 0);
      chk("drained_uf",    32'(r_underflow), 0);

      // underflow: r_en still high while empty
      tick();
      chk("uf_pulse", 32'(r_underflow), 1);
      chk("uf_ptr",   32'(r_ptr_gray), 5'h18);
      chk("uf_addr",  32'(r_addr), 0);
      r_en = 1'b0;
      tick();
      chk("uf_clear", 32'(r_underflow), 0);
      chk("uf_ptr2",  32'(r_ptr_gray), 5'h18);

      // wrap: five more writes (total 21), popped across the MSB-set half
      w_ptr_dir = 5'h1F;
      repeat (3) tick();
      chk("wrap_level", 32'(r_level), 5);
      for (int i = 0; i < 5; i++) begin
         chk("wrap_noempty", 32'(r_empty), 0);
         chk("wrap_addr",    32'(r_addr), 32'(i));
         chk("wrap_lvl",     32'(r_level), 32'(5 - i));
         chk("wrap_data",    32'(r_data), 32'(8'(i * 7 + 3)));
         r_en = 1'b1;
         tick();
      end
      r_en = 1'b0;
      chk("wrap_empty", 32'(r_empty), 1);
      chk("wrap_ptr",   32'(r_ptr_gray), 5'h1F);
      chk("wrap_addr5", 32'(r_addr), 5);

      // concurrent random writes (independent w_clk) and gated pops
      r_rst_n = 1'b0;
      #1;
      wr_on = 1'b1;
      tick();
      r_rst_n = 1'b1;
      wr_go   = 1'b1;
      for (int c = 0; c < 800; c++) begin
         pop = 1'b0;
         if (!r_empty) begin
            chk("rnd_sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
            if (sb.size() > 0) chk("rnd_data", 32'(r_data), 32'(sb[0]));
            pop = ($urandom_range(0, 3) != 0);
         end
         r_en = pop;
         tick();
         if (pop) begin
            void'(sb.pop_front());
            pop_cnt++;
         end
         occ = w_cnt - pop_cnt;
         chk("rnd_uf", 32'(r_underflow), 0);
         chk("rnd_level_le_occ", (int'(r_level) <= occ) ? 1 : 0, 1);
      end
      wr_go = 1'b0;
      guard = 0;
      while (!(r_empty && pop_cnt == w_cnt) && guard < 300) begin
         pop = !r_empty;
         if (pop && sb.size() > 0) chk("fin_data", 32'(r_data), 32'(sb[0]));
         r_en = pop;
         tick();
         if (pop) begin
            void'(sb.pop_front());
            pop_cnt++;
         end
         guard++;
      end
      r_en = 1'b0;
      chk("fin_timeout", (guard < 300) ? 1 : 0, 1);
      chk("fin_count",   32'(pop_cnt), 32'(w_cnt));
      chk("fin_empty",   32'(r_empty), 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data word width.
REQ-002 SHALL have parameter DEPTH, default 16, entry count, power of 2; AW = $clog2(DEPTH).
REQ-003 SHALL have parameter AE_LEVEL, default 1, almost-empty threshold in entries.
REQ-004 SHALL have port r_clk  input  1  read-domain clock.
REQ-005 SHALL have port r_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port r_en  input  1  pop request.
REQ-007 SHALL have port w_ptr_gray  input  AW+1  write pointer in Gray code, asynchronous to r_clk.
REQ-008 SHALL have port r_ptr_gray  output  AW+1  registered read pointer in Gray code, for the write domain.
REQ-009 SHALL have port r_addr  output  AW  memory read address, equal to r_bin[AW-1:0].
REQ-010 SHALL have port mem_rdata  input  DATA_WIDTH  combinational memory read data.
REQ-011 SHALL have port r_data  output  DATA_WIDTH  show-ahead head-of-FIFO data.
REQ-012 SHALL have port r_empty  output  1  registered empty flag.
REQ-013 SHALL have port r_almost_empty  output  1  registered; high when r_level <= AE_LEVEL.
REQ-014 SHALL have port r_level  output  AW+1  registered occupancy, 0..DEPTH.
REQ-015 SHALL have port r_underflow  output  1  one-cycle pulse on pop attempted while empty.

Function
REQ-016 SHALL synchronize w_ptr_gray through two r_clk flops (wq1, wq2) before any use.
REQ-017 SHALL keep an AW+1-bit binary read pointer r_bin; pop = r_en && !r_empty.
REQ-018 On pop, r_bin_next = r_bin+1, wrapping modulo 2^(AW+1); otherwise r_bin_next = r_bin.
REQ-019 SHALL register r_ptr_gray = r_bin_next ^ (r_bin_next >> 1) on each edge; never a combinational output.
REQ-020 SHALL register r_empty <= (gray(r_bin_next) == wq2), with wq2 being the stage-2 register output.
REQ-021 SHALL convert wq2 to binary (wq2_bin) by an XOR-prefix; r_level <= wq2_bin - r_bin_next, AW+1-bit modular subtraction.
REQ-022 r_almost_empty <= (wq2_bin - r_bin_next) <= AE_LEVEL, computed from the same subtraction.
REQ-023 r_data SHALL equal mem_rdata combinationally, with no added latency; valid only while r_empty = 0.
REQ-024 Pop while r_empty = 1 SHALL leave the pointers unchanged and drive r_underflow = 1 for exactly the next cycle.
REQ-025 Latency: if w_ptr_gray is stable before edge k, r_empty/r_level SHALL reflect it after edge k+2.
REQ-026 Pop of the last entry SHALL assert r_empty after the same edge that advances r_bin.
REQ-027 Wrap-around: pointer MSB toggles every DEPTH pops; empty is detected only by full (AW+1)-bit equality.
REQ-028 Simultaneous write-pointer change and pop SHALL be handled without a lost or duplicated entry; flags stay conservative (empty or low level may persist up to 2 extra cycles, and are never falsely optimistic).

Reset
REQ-029 Assertion of r_rst_n = 0 SHALL asynchronously clear r_bin, r_ptr_gray, wq1, wq2 and r_level to 0, set r_empty = 1 and r_almost_empty = 1, and clear r_underflow to 0.
REQ-030 Reset mid-operation SHALL discard any in-flight pop; the first pop is accepted no earlier than 3 cycles after deassertion, gated by r_empty.

Structure
REQ-031 Package fifo_pkg SHALL hold the bin2gray/gray2bin functions and the ptr_t typedef sized from AW.
REQ-032 The two-flop synchronizer SHALL be sub-module sync_2ff (parameter WIDTH, async active-low reset), reusable by the write side.
REQ-033 SHALL contain no memory array; it drives dualport_mem's read port.

Verification (DEPTH=16, AE_LEVEL=1)
REQ-034 Reset: r_rst_n=0 mid-clock -> immediately r_empty=1, r_ptr_gray=0, r_level=0, r_addr=0.
REQ-035 Latency: w_ptr_gray 0->1 stable before edge k -> r_empty=0, r_level=1, r_almost_empty=1 after edge k+2; r_data=mem[0].
REQ-036 Drain: w_ptr_gray=gray(16)=5'h18, 16 pops -> r_addr 0..15, r_level 16..1, r_empty=1 after the 16th pop; r_ptr_gray=5'h18.
REQ-037 Underflow: r_en=1 while empty -> r_bin unchanged, one-cycle r_underflow pulse, no r_ptr_gray change.
REQ-038 Wrap: after 16+5 writes and 21 pops, r_bin=5'd21 and r_ptr_gray=5'h1F, with no false empty at the 16/17 boundary.
REQ-039 Random concurrent writes/pops with an independent w_clk -> scoreboard order matches, no underflow on gated pops, r_level never exceeds the true occupancy.
